// File: rtl/control_fb_arbiter.sv
// Framebuffer write-port arbiter for the command engines.
//
// Several engines share one framebuffer write port. A round-robin pick is made
// from IDLE, and the winner owns the port for the whole ACTIVE phase. While it
// owns the port, its address, data and strobes go straight through to the RAM
// side. The grant ends on the owner's done pulse or on a timeout abort. One
// RELEASE cycle follows before the block returns to IDLE.
//
// Parameters
//   NUM_REQ          number of engines sharing the port (2..8)
//   TIMEOUT_CYCLES   max ACTIVE cycles per grant, 0 disables the timeout
//
// Ports
//   clk               clock
//   reset             asynchronous reset, active low
//   req               per-engine level request
//   done_in           per-engine one-cycle completion pulse
//   req_addr          per-engine framebuffer address
//   req_data          per-engine write byte
//   req_we            per-engine write enable
//   req_access_start  per-engine access start strobe
//   grant             registered one-hot grant
//   abort             one-hot, one-cycle timeout pulse to the owner
//   addr              muxed framebuffer address (0 outside ACTIVE)
//   data_out          muxed write byte (0 outside ACTIVE)
//   ram_write_enable  muxed write enable (0 outside ACTIVE)
//   ram_access_start  muxed access start (0 outside ACTIVE)
//   busy              high in ACTIVE and RELEASE

package types;
    typedef logic [16:0] fb_addr_t;
endpackage

module control_fb_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            done_in,
    input  types::fb_addr_t [NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0][7:0]       req_data,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_access_start,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            abort,
    output types::fb_addr_t               addr,
    output logic [7:0]                    data_out,
    output logic                          ram_write_enable,
    output logic                          ram_access_start,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // cnt_q holds (ACTIVE cycle number - 1), so the timeout fires when it equals
    // TIMEOUT_CYCLES-1. It saturates at TIMEOUT_CYCLES, or at all-ones when the
    // timeout is disabled.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX =
        (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT_CYCLES);

    // Starting from the top index gives req[0] first priority after reset.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    int unsigned        rr_cand;

    logic               done_hit;
    logic               tmo_hit;
    logic               abort_hit;

    // Round-robin pick: first set req bit scanning up from last winner + 1,
    // wrapping modulo NUM_REQ. The last winner itself is scanned last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_cand = (32'(last_q) + i) % NUM_REQ;
            if (!rr_found && req[rr_cand[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[IDX_W-1:0];
            end
        end
    end

    // Masking with grant_q drops done pulses from engines that do not own the port.
    assign done_hit  = |(done_in & grant_q);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    // Done takes priority over a coincident timeout.
    assign abort_hit = (state_q == S_ACTIVE) && tmo_hit && !done_hit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rr_found) begin
                    state_d = S_ACTIVE;
                    grant_d = NUM_REQ'(1) << rr_idx;
                    idx_d   = rr_idx;
                end
            end
            S_ACTIVE: begin
                // The owner's req level is ignored here; only done or timeout end the grant.
                if (done_hit || tmo_hit) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    last_d  = idx_q;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= LAST_IDX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // The port mux is gated on ACTIVE. An async reset drops state_q to IDLE,
    // which forces every output to zero without waiting for a clock.
    always_comb begin
        addr             = '0;
        data_out         = '0;
        ram_write_enable = 1'b0;
        ram_access_start = 1'b0;
        if (state_q == S_ACTIVE) begin
            addr             = req_addr[idx_q];
            data_out         = req_data[idx_q];
            ram_write_enable = req_we[idx_q];
            ram_access_start = req_access_start[idx_q];
        end
    end

    assign grant = grant_q;
    assign abort = abort_hit ? grant_q : '0;
    assign busy  = (state_q == S_ACTIVE) || (state_q == S_RELEASE);

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
    a_abort_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(abort));
    a_abort_owner   : assert property (@(posedge clk) disable iff (!reset)
                                       (abort & ~grant) == '0);
    a_active_grant  : assert property (@(posedge clk) disable iff (!reset)
                                       (state_q == S_ACTIVE) |-> $onehot(grant_q));

endmodule

// File: tb/tb_control_fb_arbiter.sv
module tb_control_fb_arbiter;

    logic                     clk;
    logic                     reset;
    logic [3:0]               req;
    logic [3:0]               done_in;
    types::fb_addr_t [3:0]    req_addr;
    logic [3:0][7:0]          req_data;
    logic [3:0]               req_we;
    logic [3:0]               req_as;

    logic [3:0]               grant, abort;
    types::fb_addr_t          addr;
    logic [7:0]               data_out;
    logic                     wr_en, acc_st, busy;

    logic [3:0]               grant4, abort4;
    types::fb_addr_t          addr4;
    logic [7:0]               data4;
    logic                     wr_en4, acc_st4, busy4;

    int checks = 0;
    int errors = 0;

    control_fb_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .done_in          (done_in),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_we           (req_we),
        .req_access_start (req_as),
        .grant            (grant),
        .abort            (abort),
        .addr             (addr),
        .data_out         (data_out),
        .ram_write_enable (wr_en),
        .ram_access_start (acc_st),
        .busy             (busy)
    );

    control_fb_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .done_in          (done_in),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_we           (req_we),
        .req_access_start (req_as),
        .grant            (grant4),
        .abort            (abort4),
        .addr             (addr4),
        .data_out         (data4),
        .ram_write_enable (wr_en4),
        .ram_access_start (acc_st4),
        .busy             (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [3:0] abort;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                       input logic [3:0] a, input logic b);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.abort = a; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Fixed per-engine port inputs: engine k drives addr 0x1000+k, data 0xA4+k,
    // we = req_we[k], access_start = req_as[k].
    function automatic logic [31:0] exp_addr(input logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return 32'h1000 + k;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return 32'hA4 + k;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_bit(input logic [3:0] g, input logic [3:0] src);
        for (int k = 0; k < 4; k++) if (g[k]) return 32'(src[k]);
        return 32'h0;
    endfunction

    task automatic check_outputs(input string name, input logic [3:0] g, input logic [3:0] a,
                                 input logic b);
        check({name, " grant"}, 32'(grant), 32'(g));
        check({name, " abort"}, 32'(abort), 32'(a));
        check({name, " busy"}, 32'(busy), 32'(b));
        check({name, " addr"}, 32'(addr), exp_addr(g));
        check({name, " data"}, 32'(data_out), exp_data(g));
        check({name, " we"}, 32'(wr_en), exp_bit(g, 4'b0110));
        check({name, " start"}, 32'(acc_st), exp_bit(g, 4'b1001));
    endtask

    task automatic check4(input string name, input logic [3:0] g, input logic [3:0] a,
                          input logic b);
        check({name, " grant4"}, 32'(grant4), 32'(g));
        check({name, " abort4"}, 32'(abort4), 32'(a));
        check({name, " busy4"}, 32'(busy4), 32'(b));
    endtask

    // One clock cycle: drive inputs after the falling edge, let logic settle.
    task automatic apply(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req     = r;
        done_in = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        req     = 4'b1111;
        done_in = 4'b0000;
        #1;
        check_outputs("reset", 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset held", 4'b0000, 4'b0000, 1'b0);
        req   = 4'b0000;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        reset   = 1'b1;
        req     = '0;
        done_in = '0;
        req_we  = 4'b0110;
        req_as  = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            req_addr[k] = 17'(32'h1000 + k);
            req_data[k] = 8'(32'hA4 + k);
        end

        // Directed table: req, done_in, expected grant, abort, busy per cycle.
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0101, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        add(4'b0101, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0101, 4'b0000, 4'b0100, 4'b0000, 1'b1);
        add(4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Engine 0 drops req and engine 1 pulses done while 0 owns the port.
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0010, 4'b0001, 4'b0000, 1'b1);
        add(4'b0000, 4'b0010, 4'b0001, 4'b0000, 1'b1);
        add(4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Engine 2 never finishes: abort on ACTIVE cycle 8, then engine 3.
        add(4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int c = 1; c <= 7; c++) add(4'b1100, 4'b0000, 4'b0100, 4'b0000, 1'b1);
        add(4'b1100, 4'b0000, 4'b0100, 4'b0100, 1'b1);
        add(4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b1100, 4'b0000, 4'b1000, 4'b0000, 1'b1);
        add(4'b1100, 4'b1000, 4'b1000, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i].req, vecs[i].done);
            check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].abort, vecs[i].busy);
        end

        // All engines requesting, each finishes on its 5th ACTIVE cycle.
        do_reset();
        apply(4'b1111, 4'b0000);
        check_outputs("rr idle0", 4'b0000, 4'b0000, 1'b0);
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'(1 << (g % 4));
            for (int c = 1; c <= 5; c++) begin
                apply(4'b1111, (c == 5) ? exp_g : 4'b0000);
                check_outputs($sformatf("rr g%0d c%0d", g, c), exp_g, 4'b0000, 1'b1);
            end
            apply(4'b1111, 4'b0000);
            check_outputs($sformatf("rr g%0d release", g), 4'b0000, 4'b0000, 1'b1);
            apply(4'b1111, 4'b0000);
            check_outputs($sformatf("rr g%0d idle", g), 4'b0000, 4'b0000, 1'b0);
        end

        // Engine 1 writes 0xA5; reset dropped mid-cycle clears outputs at once.
        do_reset();
        apply(4'b0010, 4'b0000);
        check_outputs("we idle", 4'b0000, 4'b0000, 1'b0);
        apply(4'b0010, 4'b0000);
        check_outputs("we active", 4'b0010, 4'b0000, 1'b1);
        check("we data A5", 32'(data_out), 32'hA5);
        reset = 1'b0;
        #1;
        check_outputs("async reset", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check_outputs("reset over edge", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        #1;
        check_outputs("reset release", 4'b0000, 4'b0000, 1'b0);
        apply(4'b0010, 4'b0000);
        check_outputs("first arb", 4'b0010, 4'b0000, 1'b1);

        // TIMEOUT_CYCLES=4 instance: done on cycle 4 beats the timeout,
        // then a grant without done is aborted on cycle 4.
        do_reset();
        apply(4'b0001, 4'b0000);
        check4("t4 idle", 4'b0000, 4'b0000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            apply(4'b0001, 4'b0000);
            check4($sformatf("t4 c%0d", c), 4'b0001, 4'b0000, 1'b1);
        end
        apply(4'b0001, 4'b0001);
        check4("t4 done wins", 4'b0001, 4'b0000, 1'b1);
        apply(4'b0001, 4'b0000);
        check4("t4 release", 4'b0000, 4'b0000, 1'b1);
        apply(4'b0001, 4'b0000);
        check4("t4 idle2", 4'b0000, 4'b0000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            apply(4'b0001, 4'b0000);
            check4($sformatf("t4b c%0d", c), 4'b0001, 4'b0000, 1'b1);
        end
        apply(4'b0001, 4'b0000);
        check4("t4 abort", 4'b0001, 4'b0001, 1'b1);
        apply(4'b0000, 4'b0000);
        check4("t4 abort release", 4'b0000, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
